// File: rtl/pipe_skid_reg.sv
// Two-entry skid pipeline register.
//
// The main entry drives the outputs, and the skid entry catches the one beat
// that can arrive while downstream stalls. in_ready comes straight from a flop
// (!skid_valid), so there is no combinational path from out_ready back
// upstream.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   EMPTY | nothing held; out_valid=0, in_ready=1
//   ONE   | main entry holds a beat; skid is free, in_ready=1
//   TWO   | main and skid both hold beats; in_ready=0
//
// A flush squashes everything held and zeroes both entries. A beat that
// leaves on out_fire in the flush cycle has already been delivered. A beat
// offered on in_fire in the flush cycle is dropped.
//
// bubble_cnt counts the cycles where downstream was ready but there was
// nothing to give it. It saturates at its maximum value and clears only on
// reset.

module pipe_skid_reg #(
  parameter int CTRL_W = 4,
  parameter int DATA_W = 35,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  bubble_cnt
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] BUBBLE_MAX = '1;

  state_t              state;
  logic                main_valid;
  logic [CTRL_W-1:0]   main_ctrl;
  logic [DATA_W-1:0]   main_data;
  logic                skid_valid;
  logic [CTRL_W-1:0]   skid_ctrl;
  logic [DATA_W-1:0]   skid_data;
  logic [1:0]          occ_q;
  logic                in_fire;
  logic                out_fire;

  assign in_ready  = !skid_valid;
  assign out_valid = main_valid;
  assign out_data  = main_data;
  assign out_ctrl  = main_valid ? main_ctrl : '0;
  assign occupancy = occ_q;

  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;

  // Occupancy state machine: moves beats between the input, main and skid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_EMPTY;
      occ_q      <= 2'd0;
      main_valid <= 1'b0;
      main_ctrl  <= '0;
      main_data  <= '0;
      skid_valid <= 1'b0;
      skid_ctrl  <= '0;
      skid_data  <= '0;
    end else if (flush) begin
      state      <= ST_EMPTY;
      occ_q      <= 2'd0;
      main_valid <= 1'b0;
      main_ctrl  <= '0;
      main_data  <= '0;
      skid_valid <= 1'b0;
      skid_ctrl  <= '0;
      skid_data  <= '0;
    end else begin
      case (state)
        ST_EMPTY: begin
          if (in_fire) begin
            main_valid <= 1'b1;
            main_ctrl  <= in_ctrl;
            main_data  <= in_data;
            state      <= ST_ONE;
            occ_q      <= 2'd1;
          end
        end
        ST_ONE: begin
          if (in_fire && out_fire) begin
            main_ctrl <= in_ctrl;
            main_data <= in_data;
          end else if (in_fire) begin
            skid_valid <= 1'b1;
            skid_ctrl  <= in_ctrl;
            skid_data  <= in_data;
            state      <= ST_TWO;
            occ_q      <= 2'd2;
          end else if (out_fire) begin
            // Data stays put so out_data keeps showing the last beat.
            main_valid <= 1'b0;
            state      <= ST_EMPTY;
            occ_q      <= 2'd0;
          end
        end
        ST_TWO: begin
          if (out_fire) begin
            main_ctrl  <= skid_ctrl;
            main_data  <= skid_data;
            skid_valid <= 1'b0;
            state      <= ST_ONE;
            occ_q      <= 2'd1;
          end
        end
        default: begin
          state      <= ST_EMPTY;
          occ_q      <= 2'd0;
          main_valid <= 1'b0;
          skid_valid <= 1'b0;
        end
      endcase
    end
  end

  // Saturating count of cycles where downstream was ready but starved.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bubble_cnt <= '0;
    end else if (out_ready && !out_valid && !flush && (bubble_cnt != BUBBLE_MAX)) begin
      bubble_cnt <= bubble_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Directed bench for pipe_skid_reg: streaming, backpressure, flush, ctrl
// gating, bubble counting and saturation (on a CNT_W=3 copy), and async reset.

module tb_pipe_skid_reg;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_ctrl;
  logic [34:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  out_ctrl;
  logic [34:0] out_data;
  logic [1:0]  occupancy;
  logic [15:0] bubble_cnt;

  // second instance with a narrow counter for saturation
  logic        s_in_ready;
  logic        s_out_valid;
  logic        s_out_ready;
  logic [3:0]  s_out_ctrl;
  logic [34:0] s_out_data;
  logic [1:0]  s_occupancy;
  logic [2:0]  s_bubble_cnt;
  logic        s_zero;
  logic [3:0]  s_ctrl_zero;
  logic [34:0] s_data_zero;

  int n_cmp;
  int n_fail;

  pipe_skid_reg dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_ctrl    (in_ctrl),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_ctrl   (out_ctrl),
    .out_data   (out_data),
    .occupancy  (occupancy),
    .bubble_cnt (bubble_cnt)
  );

  pipe_skid_reg #(.CTRL_W(4), .DATA_W(35), .CNT_W(3)) dut_sat (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (s_zero),
    .in_valid   (s_zero),
    .in_ready   (s_in_ready),
    .in_ctrl    (s_ctrl_zero),
    .in_data    (s_data_zero),
    .out_valid  (s_out_valid),
    .out_ready  (s_out_ready),
    .out_ctrl   (s_out_ctrl),
    .out_data   (s_out_data),
    .occupancy  (s_occupancy),
    .bubble_cnt (s_bubble_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    n_cmp++; if (occupancy !== 2'd0) begin n_fail++; $display("FAIL reset_occupancy got %0d want 0", occupancy); end
    n_cmp++; if (out_ctrl !== 4'h0) begin n_fail++; $display("FAIL reset_out_ctrl got %h want 0", out_ctrl); end
    n_cmp++; if (out_data !== 35'h0) begin n_fail++; $display("FAIL reset_out_data got %h want 0", out_data); end
    n_cmp++; if (bubble_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_bubble got %0d want 0", bubble_cnt); end
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    n_cmp++; if (occupancy !== 2'd0 || out_valid !== 1'b0) begin n_fail++; $display("FAIL post_reset_idle got occ=%0d v=%b want 0/0", occupancy, out_valid); end
  endtask

  task automatic test_saturation();
    logic [2:0] exp;
    s_out_ready = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      tick();
      exp = (i > 7) ? 3'd7 : 3'(i);
      n_cmp++; if (s_bubble_cnt !== exp) begin n_fail++; $display("FAIL sat_bubble[%0d] got %0d want %0d", i, s_bubble_cnt, exp); end
    end
    s_out_ready = 1'b0;
  endtask

  task automatic test_streaming();
    logic [15:0] b0;
    b0 = bubble_cnt;
    in_valid  = 1'b1;
    in_data   = 35'd1;
    in_ctrl   = 4'd1;
    out_ready = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      tick();
      n_cmp++; if (out_valid !== 1'b1 || out_data !== 35'(k)) begin n_fail++; $display("FAIL stream_data[%0d] got v=%b d=%0h want 1/%0h", k, out_valid, out_data, k); end
      n_cmp++; if (out_ctrl !== 4'(k)) begin n_fail++; $display("FAIL stream_ctrl[%0d] got %h want %h", k, out_ctrl, 4'(k)); end
      n_cmp++; if (occupancy !== 2'd1 || in_ready !== 1'b1) begin n_fail++; $display("FAIL stream_occ[%0d] got occ=%0d rdy=%b want 1/1", k, occupancy, in_ready); end
      out_ready = 1'b1;
      if (k < 8) begin
        in_data = 35'(k + 1);
        in_ctrl = 4'(k + 1);
      end else begin
        in_valid = 1'b0;
      end
    end
    tick();
    out_ready = 1'b0;
    n_cmp++; if (occupancy !== 2'd0 || out_valid !== 1'b0) begin n_fail++; $display("FAIL stream_drain got occ=%0d v=%b want 0/0", occupancy, out_valid); end
    n_cmp++; if (bubble_cnt !== b0) begin n_fail++; $display("FAIL stream_bubble got %0d want %0d", bubble_cnt, b0); end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 35'h0_000A_AAAA;
    in_ctrl   = 4'h3;
    tick();
    in_data = 35'h4_BBBB_0000;
    in_ctrl = 4'h6;
    tick();
    in_valid = 1'b0;
    n_cmp++; if (occupancy !== 2'd2 || in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_full got occ=%0d rdy=%b want 2/0", occupancy, in_ready); end
    n_cmp++; if (out_data !== 35'h0_000A_AAAA || out_ctrl !== 4'h3) begin n_fail++; $display("FAIL bp_head got %h/%h want 000aaaaa/3", out_data, out_ctrl); end
    tick();
    n_cmp++; if (occupancy !== 2'd2 || out_data !== 35'h0_000A_AAAA) begin n_fail++; $display("FAIL bp_hold got occ=%0d d=%h want 2/000aaaaa", occupancy, out_data); end
    out_ready = 1'b1;
    tick();
    n_cmp++; if (out_valid !== 1'b1 || out_data !== 35'h4_BBBB_0000 || out_ctrl !== 4'h6) begin n_fail++; $display("FAIL bp_second got v=%b d=%h c=%h want 1/4bbbb0000/6", out_valid, out_data, out_ctrl); end
    n_cmp++; if (in_ready !== 1'b1 || occupancy !== 2'd1) begin n_fail++; $display("FAIL bp_ready got rdy=%b occ=%0d want 1/1", in_ready, occupancy); end
    tick();
    out_ready = 1'b0;
    n_cmp++; if (out_valid !== 1'b0 || occupancy !== 2'd0) begin n_fail++; $display("FAIL bp_drain got v=%b occ=%0d want 0/0", out_valid, occupancy); end
  endtask

  task automatic test_flush();
    logic [15:0] b0;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 35'h111;
    in_ctrl   = 4'h9;
    tick();
    in_data = 35'h222;
    tick();
    in_data = 35'h333;
    flush   = 1'b1;
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    n_cmp++; if (occupancy !== 2'd0 || out_valid !== 1'b0 || out_ctrl !== 4'h0) begin n_fail++; $display("FAIL flush_state got occ=%0d v=%b c=%h want 0/0/0", occupancy, out_valid, out_ctrl); end
    n_cmp++; if (out_data !== 35'h0 || in_ready !== 1'b1) begin n_fail++; $display("FAIL flush_zero got d=%h rdy=%b want 0/1", out_data, in_ready); end
    tick();
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_no_leak got v=%b d=%h want v=0", out_valid, out_data); end
    b0 = bubble_cnt;
    out_ready = 1'b1;
    flush     = 1'b1;
    tick();
    n_cmp++; if (bubble_cnt !== b0) begin n_fail++; $display("FAIL flush_bubble got %0d want %0d", bubble_cnt, b0); end
    flush = 1'b0;
    tick();
    out_ready = 1'b0;
    n_cmp++; if (bubble_cnt !== b0 + 16'd1) begin n_fail++; $display("FAIL bubble_inc got %0d want %0d", bubble_cnt, b0 + 16'd1); end
  endtask

  task automatic test_ctrl_gating();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_ctrl   = 4'b1111;
    in_data   = 35'h5A5A;
    tick();
    in_valid = 1'b0;
    n_cmp++; if (out_ctrl !== 4'b1111) begin n_fail++; $display("FAIL gate_ctrl_on got %b want 1111", out_ctrl); end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    n_cmp++; if (out_valid !== 1'b0 || out_ctrl !== 4'h0) begin n_fail++; $display("FAIL gate_ctrl_off got v=%b c=%b want 0/0000", out_valid, out_ctrl); end
    n_cmp++; if (out_data !== 35'h5A5A) begin n_fail++; $display("FAIL gate_data_keep got %h want 5a5a", out_data); end
  endtask

  task automatic test_async_reset();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_ctrl   = 4'h5;
    in_data   = 35'h77;
    tick();
    in_data = 35'h88;
    tick();
    in_valid = 1'b0;
    n_cmp++; if (occupancy !== 2'd2) begin n_fail++; $display("FAIL ar_prefill got %0d want 2", occupancy); end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || occupancy !== 2'd0) begin n_fail++; $display("FAIL ar_immediate got v=%b rdy=%b occ=%0d want 0/1/0", out_valid, in_ready, occupancy); end
    n_cmp++; if (out_ctrl !== 4'h0 || out_data !== 35'h0 || bubble_cnt !== 16'd0) begin n_fail++; $display("FAIL ar_zero got c=%h d=%h b=%0d want 0/0/0", out_ctrl, out_data, bubble_cnt); end
    tick();
    rst_n    = 1'b1;
    in_valid = 1'b1;
    in_ctrl  = 4'hC;
    in_data  = 35'h7_0000_00AB;
    tick();
    in_valid = 1'b0;
    n_cmp++; if (out_valid !== 1'b1 || out_data !== 35'h7_0000_00AB || out_ctrl !== 4'hC || occupancy !== 2'd1) begin n_fail++; $display("FAIL ar_first_beat got v=%b d=%h c=%h occ=%0d want 1/7000000ab/c/1", out_valid, out_data, out_ctrl, occupancy); end
  endtask

  initial begin
    n_cmp       = 0;
    n_fail      = 0;
    flush       = 1'b0;
    in_valid    = 1'b0;
    in_ctrl     = 4'h0;
    in_data     = 35'h0;
    out_ready   = 1'b0;
    s_out_ready = 1'b0;
    s_zero      = 1'b0;
    s_ctrl_zero = 4'h0;
    s_data_zero = 35'h0;
    test_reset();
    test_saturation();
    test_streaming();
    test_backpressure();
    test_flush();
    test_ctrl_gating();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_skid_reg.md
PIPE_SKID_REG -- requirements
Module: pipe_skid_reg

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
  CTRL_W  4   control-field width (reg_write, mem_read, mem_write, mem_to_reg, ...)
  DATA_W  35  data-field width (alu_result, store data, destination register, ...)
  CNT_W   16  bubble-counter width
REQ-002 Ports SHALL be, one per line: name  direction  width  meaning.
  clk         input   1       single clock; all state on rising edge
  rst_n       input   1       asynchronous active-low reset
  flush       input   1       synchronous squash of all held beats
  in_valid    input   1       upstream beat valid
  in_ready    output  1       stage can accept a beat
  in_ctrl     input   CTRL_W  upstream control field
  in_data     input   DATA_W  upstream data field
  out_valid   output  1       downstream beat valid
  out_ready   input   1       downstream accepts beat
  out_ctrl    output  CTRL_W  control field, gated by out_valid
  out_data    output  DATA_W  data field
  occupancy   output  2       beats held: 0, 1 or 2
  bubble_cnt  output  CNT_W   saturating count of downstream bubble cycles
REQ-003 Reset SHALL be one clock, asynchronous assert, active-low on rst_n, as already decided.

Function
REQ-004 Storage SHALL be one main entry driving out_* and one skid entry; each entry holds ctrl, data and a valid bit.
REQ-005 in_fire = in_valid && in_ready; out_fire = out_valid && out_ready.
REQ-006 in_ready SHALL equal !skid_valid, a registered value with no combinational path from out_ready.
REQ-007 out_valid SHALL equal main_valid; out_data SHALL equal main data.
REQ-008 out_ctrl SHALL equal main ctrl when main_valid=1 and all-zero otherwise.
REQ-009 The state machine SHALL have states EMPTY (occupancy 0), ONE (occupancy 1) and TWO (occupancy 2).
REQ-010 EMPTY: in_fire SHALL load main and go to ONE; otherwise stay in EMPTY.
REQ-011 ONE: in_fire && out_fire SHALL load main with the input and stay in ONE.
REQ-012 ONE: in_fire && !out_fire SHALL load skid and go to TWO.
REQ-013 ONE: !in_fire && out_fire SHALL clear main_valid and go to EMPTY.
REQ-014 TWO: out_fire SHALL move skid to main, clear skid_valid and go to ONE; in_fire cannot occur in TWO.
REQ-015 Beats SHALL leave in acceptance order, with no loss or duplication in the absence of flush.
REQ-016 Latency SHALL be 1 cycle from in_fire into EMPTY to out_valid=1.
REQ-017 Sustained throughput SHALL be 1 beat/cycle while out_ready=1.
REQ-018 flush SHALL take priority over all other events: the next state is EMPTY, both valid bits clear, and both entries' ctrl and data are zeroed.
REQ-019 A beat accepted by in_fire in a flush cycle SHALL be discarded.
REQ-020 A beat consumed by out_fire in a flush cycle SHALL count as delivered.
REQ-021 bubble_cnt SHALL increment by 1 in each cycle with out_ready=1, out_valid=0 and flush=0.
REQ-022 bubble_cnt SHALL saturate at 2^CNT_W-1 and SHALL clear only on reset.
REQ-023 occupancy SHALL be a registered encoding of the state: EMPTY=0, ONE=1, TWO=2; the value 3 never occurs.

Reset
REQ-024 While rst_n=0, the block SHALL immediately hold: state EMPTY, main_valid=0, skid_valid=0, all ctrl/data zero, bubble_cnt=0, occupancy=0.
REQ-025 While rst_n=0, outputs SHALL be out_valid=0, out_ctrl=0 and in_ready=1.
REQ-026 Reset asserted mid-transfer SHALL discard all held beats; the first rising edge after deassertion behaves as EMPTY.

Verification
REQ-027 Streaming: out_ready=1, 8 beats data=1..8 on consecutive cycles -> out_data=1..8 on consecutive cycles, each 1 cycle later; occupancy stays <=1; bubble_cnt unchanged.
REQ-028 Backpressure: send A, B with out_ready=0 -> occupancy=2, in_ready=0; raise out_ready -> A then B delivered; in_ready=1 the cycle after A leaves.
REQ-029 Flush with occupancy 2 and in_valid=1 -> next cycle occupancy=0, out_valid=0, out_ctrl=0; the input beat never appears on the output.
REQ-030 Control gating: ctrl=4'b1111 beat consumed, then idle -> out_ctrl=0 while out_valid=0, out_data retains its last value.
REQ-031 Saturation: CNT_W=3, out_ready=1, idle for 10 cycles -> bubble_cnt reads 1..7 and then holds at 7.
REQ-032 Async reset pulse mid-cycle at occupancy 2 -> all outputs reach reset values before the next edge; a new beat is accepted on the first edge after release.
